branch_history_tracker: RTL and testbench
=========================================

# branch_history_tracker

Speculative global-history and in-flight-branch bookkeeping for the gshare predictor. Supplies the predictor's read-side history (`bhr`) and drives its write port (`wr_en`, `wr_taken`, `wr_index`). It checkpoints the history and table index of each predicted branch in a circular buffer. It restores history on mispredict and retires resolved branches in order.

## Interface
- `DEPTH`, default `` `BRANCH_HISTORY_TABLE_SIZE ``: predictor table entries. `LOG_DEPTH = $clog2(DEPTH)`, which is also the history width.
- `NUM_BRANCHES`, default 8: maximum in-flight branches, power of two. `TAG_W = $clog2(NUM_BRANCHES)`.
- `clock` in 1: single clock; everything is posedge.
- `reset` in 1: synchronous, active-high.
- `pred_valid` in 1: fetch presents a predicted conditional branch.
- `pred_taken` in 1: predicted direction from the predictor.
- `pred_index` in `LOG_DEPTH`: index used for the prediction (the predictor's `out_index`).
- `alloc_ok` out 1: combinational; the branch is accepted this cycle.
- `alloc_tag` out `TAG_W`: combinational; tag assigned to the accepted branch (current tail).
- `bhr` out `LOG_DEPTH`: registered speculative global history, feeds the predictor's `rd_bhr`.
- `resolve_valid` in 1: a branch resolved this cycle.
- `resolve_tag` in `TAG_W`: tag of the resolving branch.
- `resolve_taken` in 1: actual direction.
- `resolve_mispredict` in 1: actual direction differs from predicted.
- `wr_en`, `wr_taken` out 1; `wr_index` out `LOG_DEPTH`: predictor counter update.
- `full` out 1: `count == NUM_BRANCHES`.
- `count` out `TAG_W+1`: live entries.

## Operation
- Per-entry state: `valid`, `resolved`, `index`, `ckpt_bhr` (history before this branch's shift).
- State: `head`, `tail` (mod `NUM_BRANCHES`), `count`, `bhr`.
- Alloc rule: `alloc_ok = pred_valid && !full && !(resolve_valid && resolve_mispredict && live(resolve_tag))`.
- On `alloc_ok`:
  - entry[tail] ← {valid=1, resolved=0, index=pred_index, ckpt_bhr=bhr}
  - tail++
  - `bhr ← {bhr[LOG_DEPTH-2:0], pred_taken}`
- `live(t)` = `valid[t]` and not `resolved[t]`. Resolve on a non-live tag is ignored entirely: no write, no state change.
- Live resolve:
  - `resolved[tag] ← 1`.
  - Issue predictor update: `wr_index = entry.index`, `wr_taken = resolve_taken`.
- Live mispredict:
  - `bhr ← {ckpt_bhr[tag][LOG_DEPTH-2:0], resolve_taken}`.
  - Squash all entries younger than tag: clear `valid`, set `tail ← tag+1`, `count ← ((tag-head) mod N)+1 - retire`.
  - Squashed entries never issue updates.
- Retire: if `count>0 && valid[head] && resolved[head]`, clear `valid[head]`, `head++`, `count--`. At most one per cycle.
- Same cycle alloc + retire: `count` unchanged. Mispredict + alloc: alloc suppressed (`alloc_ok=0`) and mispredict applied.
- All pointer arithmetic wraps modulo `NUM_BRANCHES`; history shifts drop the MSB.

## Timing
- Reset values: `bhr=0`, `head=tail=0`, `count=0`, all `valid=0`, `full=0`, `wr_en=0`, `wr_taken=0`, `wr_index=0`.
- Reset asserted mid-operation discards all entries. A resolve coincident with reset is ignored.
- `bhr`, `full`, and `count` reflect an alloc, mispredict, or retire one cycle after the event.
- A resolved entry retires no earlier than the cycle after its resolve.

## Configuration
- `BTRACK_WR_REG_EN` defined: `wr_*` registered, asserted the cycle after the resolve, `wr_en` high for exactly one cycle.
- `BTRACK_WR_REG_EN` undefined: `wr_*` combinational from the resolve inputs in the same cycle; `wr_en = resolve_valid && live(resolve_tag)`; `wr_index`/`wr_taken` are 0 when `wr_en=0`.

## Test plan
(`DEPTH=16`, `NUM_BRANCHES=4`, `BTRACK_WR_REG_EN` defined.)
- Reset, then idle → `bhr=0`, `count=0`, `full=0`, `wr_en=0`.
- Alloc (`index=5`, taken), then (`index=3`, not taken) → `alloc_tag` 0 then 1; `bhr` 0001 then 0010; `count=2`.
- Resolve tag 0, taken, no mispredict → next cycle `wr_en=1`, `wr_index=5`, `wr_taken=1`; following cycle `count=1`, `head=1`.
- Four allocs → `full=1`; a fifth `pred_valid` gives `alloc_ok=0`; `bhr` and `count` are unchanged.
- Allocs at `bhr` 0000→tags 0,1,2 taken (`bhr=0111`); mispredict tag 1, actual not taken → `bhr=0010`, `count=2`; next alloc gets `alloc_tag=2`; a resolve on the old tag 2 before that alloc produces no write.
- Mispredict on a live tag while `pred_valid=1` → `alloc_ok=0`, `tail=tag+1`; a resolve of an already resolved tag → ignored, `wr_en=0`.

Source files
------------

// File: rtl/branch_history_tracker.sv
// Speculative global history and in-flight branch checkpoint buffer for the gshare predictor.
// Define BTRACK_WR_REG_EN to register the predictor write port one cycle after the resolve.
`ifndef BRANCH_HISTORY_TABLE_SIZE
`define BRANCH_HISTORY_TABLE_SIZE 16
`endif

module branch_history_tracker #(
  parameter  int DEPTH        = `BRANCH_HISTORY_TABLE_SIZE,
  parameter  int NUM_BRANCHES = 8,
  localparam int LOG_DEPTH    = $clog2(DEPTH),
  localparam int TAG_W        = $clog2(NUM_BRANCHES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pred_valid,
  input  logic                 pred_taken,
  input  logic [LOG_DEPTH-1:0] pred_index,
  output logic                 alloc_ok,
  output logic [TAG_W-1:0]     alloc_tag,
  output logic [LOG_DEPTH-1:0] bhr,
  input  logic                 resolve_valid,
  input  logic [TAG_W-1:0]     resolve_tag,
  input  logic                 resolve_taken,
  input  logic                 resolve_mispredict,
  output logic                 wr_en,
  output logic                 wr_taken,
  output logic [LOG_DEPTH-1:0] wr_index,
  output logic                 full,
  output logic [TAG_W:0]       count
);

  logic [NUM_BRANCHES-1:0] valid_r;
  logic [NUM_BRANCHES-1:0] resolved_r;
  logic [LOG_DEPTH-1:0]    index_r [NUM_BRANCHES];
  logic [LOG_DEPTH-1:0]    ckpt_r  [NUM_BRANCHES];
  logic [TAG_W-1:0]        head_r;
  logic [TAG_W-1:0]        tail_r;
  logic [TAG_W:0]          count_r;
  logic [LOG_DEPTH-1:0]    bhr_r;
  logic                    full_r;

  logic                    live_s;
  logic                    resolve_s;
  logic                    mispredict_s;
  logic                    retire_s;
  logic [NUM_BRANCHES-1:0] squash_s;
  logic [TAG_W-1:0]        head_nx_s;
  logic [TAG_W-1:0]        tail_nx_s;
  logic [TAG_W:0]          count_nx_s;
  logic [LOG_DEPTH-1:0]    bhr_nx_s;

  // Position of a slot relative to the oldest entry; larger means younger.
  function automatic logic [TAG_W-1:0] age(input logic [TAG_W-1:0] slot, input logic [TAG_W-1:0] head);
    return slot - head;
  endfunction

  // Resolve qualification, allocation, retirement and next pointer/history state.
  always_comb begin
    live_s       = valid_r[resolve_tag] && !resolved_r[resolve_tag];
    resolve_s    = resolve_valid && live_s;
    mispredict_s = resolve_s && resolve_mispredict;
    alloc_ok     = pred_valid && !full_r && !mispredict_s;
    alloc_tag    = tail_r;
    retire_s     = (count_r != {(TAG_W+1){1'b0}}) && valid_r[head_r] && resolved_r[head_r];
    squash_s     = {NUM_BRANCHES{1'b0}};
    if (retire_s) begin
      head_nx_s = head_r + {{(TAG_W-1){1'b0}}, 1'b1};
    end else begin
      head_nx_s = head_r;
    end
    if (mispredict_s) begin
      tail_nx_s  = resolve_tag + {{(TAG_W-1){1'b0}}, 1'b1};
      count_nx_s = {1'b0, age(resolve_tag, head_r)} + (TAG_W+1)'(1) - (TAG_W+1)'(retire_s);
      bhr_nx_s   = {ckpt_r[resolve_tag][LOG_DEPTH-2:0], resolve_taken};
      for (int i = 0; i < NUM_BRANCHES; i++) begin
        squash_s[i] = age(TAG_W'(i), head_r) > age(resolve_tag, head_r);
      end
    end else if (alloc_ok) begin
      tail_nx_s  = tail_r + {{(TAG_W-1){1'b0}}, 1'b1};
      count_nx_s = count_r + (TAG_W+1)'(1) - (TAG_W+1)'(retire_s);
      bhr_nx_s   = {bhr_r[LOG_DEPTH-2:0], pred_taken};
    end else begin
      tail_nx_s  = tail_r;
      count_nx_s = count_r - (TAG_W+1)'(retire_s);
      bhr_nx_s   = bhr_r;
    end
  end

  // Pointer, history and per-entry state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r     <= {TAG_W{1'b0}};
      tail_r     <= {TAG_W{1'b0}};
      count_r    <= {(TAG_W+1){1'b0}};
      bhr_r      <= {LOG_DEPTH{1'b0}};
      full_r     <= 1'b0;
      valid_r    <= {NUM_BRANCHES{1'b0}};
      resolved_r <= {NUM_BRANCHES{1'b0}};
      for (int i = 0; i < NUM_BRANCHES; i++) begin
        index_r[i] <= {LOG_DEPTH{1'b0}};
        ckpt_r[i]  <= {LOG_DEPTH{1'b0}};
      end
    end else begin
      head_r  <= head_nx_s;
      tail_r  <= tail_nx_s;
      count_r <= count_nx_s;
      bhr_r   <= bhr_nx_s;
      full_r  <= (count_nx_s == (TAG_W+1)'(NUM_BRANCHES));
      for (int i = 0; i < NUM_BRANCHES; i++) begin
        if (squash_s[i]) begin
          valid_r[i] <= 1'b0;
        end else if (retire_s && (head_r == TAG_W'(i))) begin
          valid_r[i] <= 1'b0;
        end else if (alloc_ok && (tail_r == TAG_W'(i))) begin
          valid_r[i]    <= 1'b1;
          resolved_r[i] <= 1'b0;
          index_r[i]    <= pred_index;
          ckpt_r[i]     <= bhr_r;
        end else begin
          valid_r[i] <= valid_r[i];
        end
        // A resolving entry is live, so it can never be the slot being allocated.
        if (resolve_s && (resolve_tag == TAG_W'(i))) begin
          resolved_r[i] <= 1'b1;
        end
      end
    end
  end

`ifdef BTRACK_WR_REG_EN
  logic                 wr_en_r;
  logic                 wr_taken_r;
  logic [LOG_DEPTH-1:0] wr_index_r;

  // Predictor update registered one cycle behind the resolve.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_r    <= 1'b0;
      wr_taken_r <= 1'b0;
      wr_index_r <= {LOG_DEPTH{1'b0}};
    end else if (resolve_s) begin
      wr_en_r    <= 1'b1;
      wr_taken_r <= resolve_taken;
      wr_index_r <= index_r[resolve_tag];
    end else begin
      wr_en_r    <= 1'b0;
      wr_taken_r <= 1'b0;
      wr_index_r <= {LOG_DEPTH{1'b0}};
    end
  end

  assign wr_en    = wr_en_r;
  assign wr_taken = wr_taken_r;
  assign wr_index = wr_index_r;
`else
  // Predictor update driven straight from the resolve inputs, quiet during reset.
  always_comb begin
    if (resolve_s && !reset) begin
      wr_en    = 1'b1;
      wr_taken = resolve_taken;
      wr_index = index_r[resolve_tag];
    end else begin
      wr_en    = 1'b0;
      wr_taken = 1'b0;
      wr_index = {LOG_DEPTH{1'b0}};
    end
  end
`endif

  assign bhr   = bhr_r;
  assign full  = full_r;
  assign count = count_r;

endmodule

// File: tb/tb_branch_history_tracker.sv
// Randomized bench for branch_history_tracker against a queue-based in-flight branch model.
module tb_branch_history_tracker;
  localparam int NB = 4;
  localparam int HMASK = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pred_valid = 1'b0, pred_taken = 1'b0;
  logic [3:0] pred_index = 4'd0;
  logic       alloc_ok;
  logic [1:0] alloc_tag;
  logic [3:0] bhr;
  logic       resolve_valid = 1'b0, resolve_taken = 1'b0, resolve_mispredict = 1'b0;
  logic [1:0] resolve_tag = 2'd0;
  logic       wr_en, wr_taken;
  logic [3:0] wr_index;
  logic       full;
  logic [2:0] count;

  branch_history_tracker #(.DEPTH(16), .NUM_BRANCHES(NB)) dut (
    .clock(clock), .reset(reset), .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_index(pred_index), .alloc_ok(alloc_ok), .alloc_tag(alloc_tag), .bhr(bhr),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
    .resolve_mispredict(resolve_mispredict), .wr_en(wr_en), .wr_taken(wr_taken),
    .wr_index(wr_index), .full(full), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {int tag; int index; int ckpt; bit resolved;} br_t;
  br_t q[$];
  int  m_head = 0;
  int  m_bhr = 0;
  int  pw_en = 0, pw_taken = 0, pw_index = 0;
  int  total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit rst, input bit pv, input bit pt, input int pi,
                      input bit rv, input int rt, input bit rtk, input bit rm);
    int pos, etag, cw_en, cw_idx, cw_tk;
    bit live, mis, alloc, ret;
    @(negedge clock);
    reset = rst; pred_valid = pv; pred_taken = pt; pred_index = 4'(pi);
    resolve_valid = rv; resolve_tag = 2'(rt); resolve_taken = rtk; resolve_mispredict = rm;
    #1;
    pos = -1;
    if (!rst && rv)
      for (int i = 0; i < q.size(); i++)
        if (q[i].tag == rt && !q[i].resolved) pos = i;
    live  = (pos >= 0);
    mis   = live && rm;
    alloc = pv && (q.size() < NB) && !mis;
    ret   = (q.size() > 0) && q[0].resolved;
    etag  = (m_head + q.size()) % NB;
    cw_en  = live ? 1 : 0;
    cw_idx = live ? q[pos].index : 0;
    cw_tk  = live ? int'(rtk) : 0;

    chk("bhr", 32'(bhr), 32'(m_bhr));
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), (q.size() == NB) ? 32'd1 : 32'd0);
    if (!rst) begin
      chk("alloc_ok", 32'(alloc_ok), 32'(alloc));
      if (alloc) chk("alloc_tag", 32'(alloc_tag), 32'(etag));
    end
`ifdef BTRACK_WR_REG_EN
    chk("wr_en", 32'(wr_en), 32'(pw_en));
    chk("wr_index", 32'(wr_index), 32'(pw_index));
    chk("wr_taken", 32'(wr_taken), 32'(pw_taken));
    pw_en = cw_en; pw_index = cw_idx; pw_taken = cw_tk;
`else
    chk("wr_en", 32'(wr_en), 32'(cw_en));
    chk("wr_index", 32'(wr_index), 32'(cw_idx));
    chk("wr_taken", 32'(wr_taken), 32'(cw_tk));
`endif

    if (rst) begin
      q.delete(); m_head = 0; m_bhr = 0;
    end else begin
      if (ret) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % NB;
        if (live) pos--;
      end
      if (live) begin
        q[pos].resolved = 1'b1;
        if (mis) begin
          m_bhr = ((q[pos].ckpt << 1) | int'(rtk)) & HMASK;
          while (q.size() > pos + 1) void'(q.pop_back());
        end
      end
      if (alloc) begin
        q.push_back('{etag, pi & HMASK, m_bhr, 1'b0});
        m_bhr = ((m_bhr << 1) | int'(pt)) & HMASK;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int rt;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Two allocs, then a correct resolve of the oldest.
    step(0, 1, 1, 5, 0, 0, 0, 0);
    step(0, 1, 0, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    idle(3);
    // Fill to full, fifth request must be refused.
    for (int i = 0; i < 5; i++) step(0, 1, i[0], 7 + i, 0, 0, 0, 0);
    idle(1);
    // Mispredict with a simultaneous alloc request and stale-tag resolves.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 9 + i, 0, 0, 0, 0);
    step(0, 1, 1, 12, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1, 2, 1, 0);
    step(0, 1, 0, 4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    idle(3);
    // Random traffic with occasional reset coinciding with a live resolve.
    for (int n = 0; n < 600; n++) begin
      if (q.size() > 0 && ($urandom % 4) != 0) rt = q[$urandom % q.size()].tag;
      else rt = int'($urandom % NB);
      if (($urandom % 97) == 0)
        step(1, 1, 1, int'($urandom % 16), 1, rt, 1, 1);
      else
        step(0, ($urandom % 4) != 0, $urandom % 2, int'($urandom % 16),
             $urandom % 2, rt, $urandom % 2, ($urandom % 4) == 0);
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
